// File: rtl/serial_subtractor_32.sv
// Bit-serial a - b: one full-subtractor cell plus a borrow flop, LSB first, one bit per clock.
// Latency: start accepted at edge k, result registered at edge k+N, done high the cycle after.
// Backpressure: none; start is ignored while busy, and results hold until the next completion.
module serial_subtractor_32 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  // Holds the low N-1 result bits; the final bit goes straight into diff.
  logic [N-2:0]   res_sh;
  logic           br;

  logic           launch;
  logic           last_bit;
  logic           a_i;
  logic           b_i;
  logic           d_bit;
  logic           br_nxt;

  // A start is accepted whenever the datapath is not mid-operation.
  assign launch   = start && (state != RUN);
  assign last_bit = (state == RUN) && (cnt == CW'(N - 1));

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign a_i    = a_sh[0];
  assign b_i    = b_sh[0];
  assign d_bit  = a_i ^ b_i ^ br;
  assign br_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & br);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE can relaunch directly so back-to-back ops have no idle gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last_bit ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state; busy and done are mutually exclusive.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and per-bit shifting; cnt saturates at N-1 and restarts on launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else if (launch) begin
      a_sh <= a;
      b_sh <= b;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh       <= a_sh >> 1;
      b_sh       <= b_sh >> 1;
      res_sh     <= res_sh >> 1;
      res_sh[N-2] <= d_bit;
      br         <= br_nxt;
      if (!last_bit) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Visible results change only on the final bit, so partial sums never leak out.
  // On that bit a_i/b_i are the operand MSBs, which is all signed overflow needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (last_bit) begin
      diff       <= {d_bit, res_sh};
      borrow_out <= br_nxt;
      overflow   <= (a_i ^ b_i) & (d_bit ^ a_i);
    end
  end

endmodule
